// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  function automatic logic is_div(input op_e op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the datapath: radix-2 shift-add for multiply, restoring
// shift-subtract for divide, on a double-width {upper, lower} accumulator.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e                op,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Multiply keeps the adder carry as the new top bit after the right shift;
  // divide shifts the next dividend bit into the partial remainder first.
  always_comb begin
    sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    trial = acc_in[2*WIDTH-1:WIDTH-1];
    diff  = trial - {1'b0, operand};
    if (is_div(op)) begin
      if (trial >= {1'b0, operand}) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers,
// start/busy/done handshake, abort, and direct HI/LO writes.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Abort,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  op_e                op_in;
  logic               signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes are taken as unsigned, so |MIN| fits and MIN / -1 yields MIN.
  always_comb begin
    op_in     = op_e'(Op);
    signed_op = (op_in == MULT) || (op_in == DIV);
    mag_a     = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b     = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= MULT;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWe) Hi <= WrData;
          if (LoWe) Lo <= WrData;
          if (Start) begin
            op_q    <= op_in;
            cnt     <= CNT_W'(WIDTH);
            Busy    <= 1'b1;
            neg_res <= signed_op & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_rem <= signed_op & SrcA[WIDTH-1];
            // Divide by zero skips the iterations; acc carries the final Hi/Lo.
            if (is_div(op_in) && (SrcB == '0)) begin
              dz    <= 1'b1;
              acc   <= {SrcA, {WIDTH{1'b1}}};
              state <= FIX;
            end else begin
              dz      <= 1'b0;
              acc     <= {{WIDTH{1'b0}}, is_div(op_in) ? mag_a : mag_b};
              operand <= is_div(op_in) ? mag_b : mag_a;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          Busy  <= 1'b0;
          if (!Abort) begin
            Done    <= 1'b1;
            DivZero <= dz;
            if (dz) begin
              {Hi, Lo} <= acc;
            end else if (is_div(op_q)) begin
              Hi <= rem_fix;
              Lo <= quo_fix;
            end else begin
              {Hi, Lo} <= prod_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at WIDTH=32.
module tb_mdu_iterative;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Abort = 1'b0;
  logic        HiWe = 1'b0;
  logic        LoWe = 1'b0;
  logic [31:0] WrData = '0;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Start   (Start),
    .Op      (Op),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Abort   (Abort),
    .HiWe    (HiWe),
    .LoWe    (LoWe),
    .WrData  (WrData),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Called just after a falling edge; the request is held across one rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op    = op;
    SrcA  = a;
    SrcB  = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = 0;
    while (Done !== 1'b1 && cycles < limit) begin
      if (Busy === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input logic expDz, input int expCycles);
    int cycles;
    int busyCycles;
    applyStimulus(op, a, b);
    waitDone(60, cycles, busyCycles);
    checkOutput({tag, "_done"}, 32'(Done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expCycles));
    checkOutput({tag, "_hi"}, Hi, expHi);
    checkOutput({tag, "_lo"}, Lo, expLo);
    checkOutput({tag, "_divzero"}, 32'(DivZero), 32'(expDz));
  endtask

  initial begin
    int cycles;
    int busyCycles;
    int doneSeen;

    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 32'(Busy), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_divzero", 32'(DivZero), 32'd0);
    checkOutput("reset_hi", Hi, 32'd0);
    checkOutput("reset_lo", Lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(60, cycles, busyCycles);
    checkOutput("multu_max_latency", 32'(cycles), 32'd33);
    checkOutput("multu_max_busy_cycles", 32'(busyCycles), 32'd33);
    checkOutput("multu_max_done", 32'(Done), 32'd1);
    checkOutput("multu_max_busy_at_done", 32'(Busy), 32'd0);
    checkOutput("multu_max_hi", Hi, 32'hFFFF_FFFE);
    checkOutput("multu_max_lo", Lo, 32'h0000_0001);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(Done), 32'd0);

    runOp("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
    runOp("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    runOp("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33);
    runOp("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    runOp("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
    runOp("multu_2_3", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 33);

    // Second Start and HiWe while busy must both be ignored.
    applyStimulus(OP_MULT, 32'd100, 32'hFFFF_FFFC);
    repeat (3) @(negedge clk);
    applyStimulus(OP_MULTU, 32'd9, 32'd9);
    checkOutput("start_while_busy_busy", 32'(Busy), 32'd1);
    WrData = 32'h0000_5555;
    HiWe   = 1'b1;
    @(negedge clk);
    HiWe = 1'b0;
    checkOutput("hiwe_while_busy", Hi, 32'd0);
    waitDone(60, cycles, busyCycles);
    checkOutput("mult_ignored_start_done", 32'(Done), 32'd1);
    checkOutput("mult_ignored_start_hi", Hi, 32'hFFFF_FFFF);
    checkOutput("mult_ignored_start_lo", Lo, 32'hFFFF_FE70);
    @(negedge clk);
    checkOutput("start_not_queued", 32'(Busy), 32'd0);

    WrData = 32'h0000_ABCD;
    HiWe   = 1'b1;
    @(negedge clk);
    HiWe = 1'b0;
    checkOutput("hiwe_idle_hi", Hi, 32'h0000_ABCD);
    checkOutput("hiwe_idle_lo", Lo, 32'hFFFF_FE70);
    WrData = 32'h0000_1111;
    LoWe   = 1'b1;
    @(negedge clk);
    LoWe = 1'b0;
    checkOutput("lowe_idle_lo", Lo, 32'h0000_1111);
    checkOutput("lowe_idle_hi", Hi, 32'h0000_ABCD);

    runOp("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1);

    // Abort on the tenth cycle of a divide leaves HI/LO/DivZero alone.
    applyStimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    checkOutput("abort_busy", 32'(Busy), 32'd0);
    checkOutput("abort_done", 32'(Done), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done === 1'b1) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_hi", Hi, 32'd5);
    checkOutput("abort_lo", Lo, 32'hFFFF_FFFF);
    checkOutput("abort_divzero", 32'(DivZero), 32'd1);

    Abort = 1'b1;
    applyStimulus(OP_DIVU, 32'd7, 32'd2);
    Abort = 1'b0;
    checkOutput("abort_start_idle_busy", 32'(Busy), 32'd1);
    waitDone(60, cycles, busyCycles);
    checkOutput("abort_start_idle_done", 32'(Done), 32'd1);
    checkOutput("abort_start_idle_hi", Hi, 32'd1);
    checkOutput("abort_start_idle_lo", Lo, 32'd3);
    checkOutput("abort_start_idle_divzero", 32'(DivZero), 32'd0);

    // Asynchronous reset mid-run, asserted away from any clock edge.
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", 32'(Busy), 32'd0);
    checkOutput("async_reset_done", 32'(Done), 32'd0);
    checkOutput("async_reset_divzero", 32'(DivZero), 32'd0);
    checkOutput("async_reset_hi", Hi, 32'd0);
    checkOutput("async_reset_lo", Lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done === 1'b1) doneSeen++;
    end
    checkOutput("async_reset_no_done", 32'(doneSeen), 32'd0);
    checkOutput("async_reset_idle", 32'(Busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO result registers.
- Successor to the single-cycle ALU multiply/divide path; removes the combinational `*`, `/` and `%` from the execute stage.
- Sits beside the ALU in EX. Pipeline control issues ops with a start/busy/done handshake, stalls on Busy, and reads Hi/Lo for MFHI/MFLO.
- Adds behaviour the ALU lacks: width generality, abort, direct HI/LO writes (MTHI/MTLO), divide-by-zero flagging.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  request; accepted only when Busy=0.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled on accept.
- SrcA  in  WIDTH  multiplicand / dividend (rs); sampled on accept.
- SrcB  in  WIDTH  multiplier / divisor (rt); sampled on accept.
- Abort  in  1  cancels the in-flight op; Hi/Lo are left unchanged.
- HiWe  in  1  direct write of Hi from WrData (MTHI).
- LoWe  in  1  direct write of Lo from WrData (MTLO).
- WrData  in  WIDTH  data for HiWe/LoWe.
- Busy  out  1  op in flight.
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result.
- DivZero  out  1  sticky flag: last completed op was a divide by zero.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Busy=0, Done=0, DivZero=0, Hi=0, Lo=0; internal counter/accumulators cleared. Reset mid-op discards the op.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start=1 at edge E latches operands and Op, stores |SrcA| and |SrcB| (magnitudes for signed ops), records result signs, counter=WIDTH.
  - Goes to RUN; for a divide with SrcB=0, goes directly to FIX.
  - Busy=1 after E.
- RUN: one iteration per cycle; counter decrements; leaves to FIX when the counter reaches 0 (WIDTH RUN cycles).
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
- FIX (one cycle):
  - Applies sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes Hi/Lo: multiply gives Hi=upper half, Lo=lower half; divide gives Lo=quotient, Hi=remainder.
  - Updates DivZero; next state IDLE; Done=1 for exactly the cycle after the FIX edge; Busy=0 from that same cycle.
- Latency:
  - Start edge E → Done high and Hi/Lo valid after edge E+WIDTH+1 (33 cycles at WIDTH=32).
  - Divide by zero → valid after edge E+1.
- Divide by zero: Lo=all ones, Hi=SrcA unchanged, DivZero=1. Any other completed op clears DivZero.
- Signed overflow: DIV of MIN by -1 gives Lo=MIN, Hi=0, with no flag.
- Start while Busy: ignored and not queued; the issuer must hold off.
- Abort: while Busy, returns to IDLE on the next edge; no Done; Hi/Lo/DivZero unchanged. Ignored in IDLE. Abort and Start together in IDLE: Start accepted.
- HiWe/LoWe:
  - Honoured only when Busy=0; ignored while Busy.
  - Coincident with an accepted Start: the write happens, and the later op result overwrites it.
  - Coincident with the FIX edge: impossible, because Busy=1 at that point.
- Hi/Lo change only on FIX, HiWe/LoWe or reset.

Decomposition:
- Package mdu_pkg holds:
  - op_e enum (MULT, MULTU, DIV, DIVU).
  - state_e enum (IDLE, RUN, FIX).
  - helper function is_div(op_e).
- One natural sub-module, mdu_step: combinational single iteration (add-shift or trial-subtract) parametrised by WIDTH, instantiated once in RUN.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001; Done exactly 33 cycles after the Start edge; Busy high for 33 cycles.
- MULT -3×5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. DIV -7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7/2 → Lo=3, Hi=1.
- DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- DIVU 0x1234/0 → Done after 2 edges, Lo=0xFFFFFFFF, Hi=0x1234, DivZero=1. Next MULTU 2×3 → Lo=6, DivZero=0.
- During a MULT, check all of:
  - Start with new operands at cycle 5 → ignored; result matches the original op.
  - HiWe while Busy → Hi unchanged.
  - HiWe=1 with WrData=0xABCD in IDLE → Hi=0xABCD next cycle.
- Abort at cycle 10 of a DIV → Busy=0 next cycle, no Done, Hi/Lo keep their prior values. Repeat with rst_n pulsed low mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
